mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
// Multi-cycle multiply/divide sequencer for the EX stage of the pipeline CPU.
// Executes MULT/MULTU/DIV/DIVU iteratively (radix-2, one bit per cycle), owns the HI/LO registers,
// and raises a stall request so the hazard unit freezes IF/ID/EX while an operation is in flight.
// Also services MTHI/MTLO writes and supplies HI/LO to the MFHI/MFLO forwarding path.
// PARAMETERS
// XLEN       32  operand / HI / LO width; the iteration count equals XLEN
// PORTS
// clk        in   1     pipeline clock; all state updates on the rising edge
// resetn     in   1     synchronous active-low reset
// start      in   1     EX issues an MD op this cycle; sampled only in IDLE
// op         in   2     0=MULT 1=MULTU 2=DIV 3=DIVU (signed = op[0]==0)
// src_a      in   XLEN  rs value: multiplicand / dividend
// src_b      in   XLEN  rt value: multiplier / divisor
// mthi       in   1     write src_a to HI (IDLE only)
// mtlo       in   1     write src_a to LO (IDLE only)
// rd_req     in   1     EX/MEM holds MFHI/MFLO and needs HI/LO this cycle
// flush      in   1     exception/branch flush of the EX-stage MD op
// busy       out  1     state != IDLE
// stall      out  1     busy & (start | rd_req | mthi | mtlo)
// done       out  1     one-cycle pulse: HI/LO have just been updated by an MD op
// hi         out  XLEN  HI register
// lo         out  XLEN  LO register
// BEHAVIOUR
// Reset (resetn==0 at edge): state=IDLE, count=0, hi=0, lo=0, done=0, busy=0; aborts any op in flight.
// FSM: IDLE -> CALC -> FIX -> IDLE.
//  IDLE: priority flush > start > mthi/mtlo. start: latch op, |src_a|,|src_b| (magnitudes if signed),
//        result signs (MUL: sa^sb; DIV quotient sa^sb, remainder sa), count=0, go CALC.
//        mthi/mtlo (no start): hi<=src_a / lo<=src_a next edge; both may assert together.
//  CALC: one iteration per cycle, count 0..XLEN-1; at count==XLEN-1 go FIX.
//        MUL: shift-add on 2*XLEN accumulator {P_hi,P_lo}, multiplier LSB-first.
//        DIV: restoring; rem = {rem,q_msb}; if rem>=divisor subtract and shift 1 into quotient.
//  FIX:  apply 2's-complement sign correction; MUL: {hi,lo}<=product; DIV: lo<=quotient, hi<=remainder;
//        done=1 for the cycle after this edge; go IDLE.
// Latency: start sampled at edge E0 -> hi/lo new and done=1 in the cycle after edge E0+XLEN+1
//          (34 cycles for XLEN=32). busy is 1 from E0 until edge E0+XLEN+1 (inclusive of FIX).
// Arithmetic: MUL is exact 2*XLEN product. Signed DIV truncates toward zero; remainder takes dividend sign.
//  Most-negative / -1 (signed): lo=0x80000000, hi=0 (wraps, no trap).
//  Divide by zero (DIV/DIVU): lo=all ones, hi=src_a (unmodified dividend); still full latency.
// Boundaries:
//  start while busy: ignored (hazard unit holds it via stall; re-presented after done).
//  mthi/mtlo while busy: ignored and stalled; applied once IDLE.
//  rd_req while busy: stall=1 until the cycle done=1; hi/lo are valid in that cycle.
//  flush in CALC/FIX: go IDLE next edge, hi/lo unchanged, no done pulse; flush in IDLE blocks start.
//  flush and resetn low together: reset wins (hi/lo cleared).
//  stall is combinational from state and inputs; done and hi/lo are registered.
// TESTING
// T1 MULT 7*6, start 1 cycle -> busy 34 cycles, done pulse cycle 34, hi=0x0, lo=0x2A.
// T2 MULT 0xFFFFFFFF*2 -> hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU same operands -> hi=0x1 lo=0xFFFFFFFE.
// T3 DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 0x80000000/0xFFFFFFFF -> lo=0 hi=0x80000000.
// T4 DIVU 5/0 -> lo=0xFFFFFFFF hi=0x5 at cycle 34; DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
// T5 flush at cycle 10 of MULT with hi=0x11 lo=0x22 preset via mthi/mtlo -> IDLE next cycle, no done, hi/lo keep 0x11/0x22.
// T6 rd_req+start held during op, mtlo during busy -> stall=1 until done, 2nd start ignored, mtlo applied after; resetn low mid-op -> hi=lo=0, busy=0 next cycle.

Source files
------------

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> multiply/divide unit bundle.
//   master (EX side):  drives start, op, src_a, src_b, mthi, mtlo, rd_req, flush;
//                      observes busy, stall, done, hi, lo.
//   slave  (mdu_ctrl): the mirror image.
// Handshake: start/mthi/mtlo/rd_req are requests held by EX. A request is
// accepted only on an edge where busy==0 and flush==0. While busy, stall is
// raised for any pending request and EX must keep presenting it until stall drops.
interface mdu_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            mthi;
    logic            mtlo;
    logic            rd_req;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, rd_req, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, rd_req, flush,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Ports:
//   clk        pipeline clock, rising edge
//   resetn     synchronous active-low reset
//   md         mdu_if.slave bundle (requests in, busy/stall/done/hi/lo out)
//   dbg_state  current FSM state (0=IDLE 1=CALC 2=FIX)
// Flow: IDLE -> CALC (XLEN iterations) -> FIX (sign correction, HI/LO write) -> IDLE.
// Operands are held as magnitudes; signs are reapplied in FIX.
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_if.slave       md,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic            is_div;
    logic            neg_q;     // sign of product / quotient
    logic            neg_r;     // sign of remainder (dividend sign)
    logic            div0;
    logic [XLEN-1:0] opb;       // multiplicand (MUL) or divisor (DIV)
    logic [XLEN-1:0] acc_hi;    // product high / partial remainder
    logic [XLEN-1:0] acc_lo;    // multiplier->product low / dividend->quotient
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            done_q;

    // control from the FSM process
    logic            load;
    logic            step;
    logic            hi_we;
    logic            lo_we;
    logic            done_d;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    // operand conditioning
    logic            is_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign is_signed = ~md.op[0];
    assign sa        = is_signed & md.src_a[XLEN-1];
    assign sb        = is_signed & md.src_b[XLEN-1];
    assign mag_a     = sa ? -md.src_a : md.src_a;
    assign mag_b     = sb ? -md.src_b : md.src_b;

    // one shift-add multiply iteration: add multiplicand if multiplier LSB set, then shift right
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n;
    logic [XLEN-1:0] mul_lo_n;

    assign mul_sum  = {1'b0, acc_hi} + ({(XLEN+1){acc_lo[0]}} & {1'b0, opb});
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};

    // one restoring divide iteration; the subtraction only matters when the
    // shifted remainder is >= divisor, so its result always fits in XLEN bits
    logic [XLEN:0]   div_tmp;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    logic [XLEN-1:0] div_hi_n;
    logic [XLEN-1:0] div_lo_n;

    assign div_tmp  = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge   = div_tmp >= {1'b0, opb};
    assign div_sub  = div_tmp[XLEN-1:0] - opb;
    assign div_hi_n = div_ge ? div_sub : div_tmp[XLEN-1:0];
    assign div_lo_n = {acc_lo[XLEN-2:0], div_ge};

    // sign correction; a zero divisor yields quotient all-ones and a remainder
    // that re-signs back to the original dividend
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign q_fix    = div0 ? {XLEN{1'b1}} : (neg_q ? -acc_lo : acc_lo);
    assign r_fix    = neg_r ? -acc_hi : acc_hi;
    assign fix_hi   = is_div ? r_fix : prod_fix[2*XLEN-1:XLEN];
    assign fix_lo   = is_div ? q_fix : prod_fix[XLEN-1:0];

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        done_d     = 1'b0;
        hi_d       = md.src_a;
        lo_d       = md.src_a;
        case (state)
            IDLE: begin
                if (md.flush) begin
                    state_next = IDLE;
                end else if (md.start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end else begin
                    hi_we = md.mthi;
                    lo_we = md.mtlo;
                end
            end
            CALC: begin
                if (md.flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == CW'(XLEN-1)) state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
                if (!md.flush) begin
                    hi_we  = 1'b1;
                    lo_we  = 1'b1;
                    hi_d   = fix_hi;
                    lo_d   = fix_lo;
                    done_d = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            opb    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_d;
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
            if (load) begin
                count  <= '0;
                is_div <= md.op[1];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                div0   <= (md.src_b == '0);
                opb    <= md.op[1] ? mag_b : mag_a;
                acc_hi <= '0;
                acc_lo <= md.op[1] ? mag_a : mag_b;
            end else if (step) begin
                count  <= count + 1'b1;
                acc_hi <= is_div ? div_hi_n : mul_hi_n;
                acc_lo <= is_div ? div_lo_n : mul_lo_n;
            end
        end
    end

    assign dbg_state = state;
    assign md.busy   = (state != IDLE);
    assign md.stall  = md.busy & (md.start | md.rd_req | md.mthi | md.mtlo);
    assign md.done   = done_q;
    assign md.hi     = hi_q;
    assign md.lo     = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl (XLEN=32) with hand-computed results.
module tb_mdu_ctrl;
    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] dbg_state;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    mdu_if #(.XLEN(32)) md ();

    mdu_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .md        (md),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        md.start  = 1'b0;
        md.op     = 2'd0;
        md.src_a  = '0;
        md.src_b  = '0;
        md.mthi   = 1'b0;
        md.mtlo   = 1'b0;
        md.rd_req = 1'b0;
        md.flush  = 1'b0;
    endtask

    // Issue one op, wait (bounded) for done, check latency and HI/LO.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        md.start = 1'b1;
        md.op    = op;
        md.src_a = a;
        md.src_b = b;
        tick();
        md.start = 1'b0;
        check({tag, " busy"}, 32'(md.busy), 32'd1);
        n = 0;
        while (!md.done && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 32'd33);
        check({tag, " hi"}, md.hi, exp_hi);
        check({tag, " lo"}, md.lo, exp_lo);
        check({tag, " idle"}, 32'(md.busy), 32'd0);
        tick();
        check({tag, " done1"}, 32'(md.done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad_stall;
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        check("rst busy", 32'(md.busy), 32'd0);
        check("rst done", 32'(md.done), 32'd0);
        check("rst hi", md.hi, 32'd0);
        check("rst lo", md.lo, 32'd0);
        check("rst state", 32'(dbg_state), 32'd0);
        resetn = 1'b1;
        tick();

        // T1..T4
        run_op("mult 7*6", 2'd0, 32'd7, 32'd6, 32'h0, 32'h2A);
        run_op("mult -1*2", 2'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu ff*2", 2'd1, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE);
        run_op("div -7/2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu 8000/ffff", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        run_op("divu 5/0", 2'd3, 32'd5, 32'd0, 32'h5, 32'hFFFFFFFF);
        run_op("div min/-1", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_op("div -5/0", 2'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // mthi and mtlo together
        md.mthi  = 1'b1;
        md.mtlo  = 1'b1;
        md.src_a = 32'hAB;
        tick();
        clear_inputs();
        check("mthilo hi", md.hi, 32'hAB);
        check("mthilo lo", md.lo, 32'hAB);

        // T5: preset HI/LO, flush a MULT mid-calculation
        md.mthi  = 1'b1;
        md.src_a = 32'h11;
        tick();
        md.mthi  = 1'b0;
        md.mtlo  = 1'b1;
        md.src_a = 32'h22;
        tick();
        clear_inputs();
        check("preset hi", md.hi, 32'h11);
        check("preset lo", md.lo, 32'h22);
        md.start = 1'b1;
        md.op    = 2'd0;
        md.src_a = 32'd7;
        md.src_b = 32'd6;
        tick();
        md.start = 1'b0;
        repeat (9) tick();
        md.flush = 1'b1;
        tick();
        md.flush = 1'b0;
        check("flush busy", 32'(md.busy), 32'd0);
        check("flush state", 32'(dbg_state), 32'd0);
        check("flush done", 32'(md.done), 32'd0);
        check("flush hi", md.hi, 32'h11);
        check("flush lo", md.lo, 32'h22);
        repeat (40) begin
            tick();
            if (md.done) break;
        end
        check("flush no done", 32'(md.done), 32'd0);
        check("flush hi keep", md.hi, 32'h11);

        // flush in IDLE blocks start
        md.flush = 1'b1;
        md.start = 1'b1;
        tick();
        clear_inputs();
        check("idle flush blocks", 32'(md.busy), 32'd0);

        // T6: requests held while busy
        md.start = 1'b1;
        md.op    = 2'd0;
        md.src_a = 32'd3;
        md.src_b = 32'd5;
        tick();
        md.src_a  = 32'd9;
        md.src_b  = 32'd9;
        md.rd_req = 1'b1;
        md.mtlo   = 1'b1;
        check("t6 stall", 32'(md.stall), 32'd1);
        n = 0;
        bad_stall = 0;
        while (!md.done && n < 40) begin
            tick();
            n++;
            if (md.busy && !md.stall) bad_stall++;
        end
        check("t6 latency", n, 32'd33);
        check("t6 stall held", bad_stall, 32'd0);
        check("t6 stall drop", 32'(md.stall), 32'd0);
        check("t6 hi", md.hi, 32'h0);
        check("t6 lo", md.lo, 32'hF);
        md.start  = 1'b0;
        md.rd_req = 1'b0;
        md.src_a  = 32'h77;
        tick();
        clear_inputs();
        check("t6 mtlo applied", md.lo, 32'h77);
        check("t6 hi keep", md.hi, 32'h0);
        check("t6 no restart", 32'(md.busy), 32'd0);

        // reset mid-op (with flush asserted at the same time)
        md.mthi  = 1'b1;
        md.src_a = 32'h55;
        tick();
        clear_inputs();
        check("pre-reset hi", md.hi, 32'h55);
        md.start = 1'b1;
        md.src_a = 32'd7;
        md.src_b = 32'd6;
        tick();
        md.start = 1'b0;
        repeat (5) tick();
        resetn   = 1'b0;
        md.flush = 1'b1;
        tick();
        resetn   = 1'b1;
        md.flush = 1'b0;
        check("midrst busy", 32'(md.busy), 32'd0);
        check("midrst hi", md.hi, 32'h0);
        check("midrst lo", md.lo, 32'h0);
        check("midrst done", 32'(md.done), 32'd0);

        // unit still works after reset
        run_op("post-rst multu", 2'd1, 32'h10000, 32'h10000, 32'h1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
